timer_bank: RTL and testbench
=============================

# timer_bank

Multi-channel millisecond timer; parametrised successor to the single-channel delay counter. Provides CHANNELS independent down-counters of WIDTH bits in TICK_HZ units, each with one-shot or periodic mode, cancel and pause. Sits beside game-logic FSMs (input debounce, animation pacing, move timeouts) that need several concurrent delays without one counter instance per user.

## Interface
- CHANNELS, 4, number of independent timers (1..16)
- WIDTH, 16, width of per-channel tick count
- TICK_HZ, 1000, tick rate; DIV = `FREQUENCY / TICK_HZ clock cycles per tick, DIV >= 2
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- cmd_valid  in  1  command strobe, one command per cycle
- cmd_ch  in  $clog2(CHANNELS) (min 1)  target channel
- cmd_op  in  2  0 START, 1 START_PERIODIC, 2 CANCEL, 3 PAUSE_TOGGLE
- cmd_value  in  WIDTH  tick count for START/START_PERIODIC; ignored otherwise
- rd_ch  in  $clog2(CHANNELS)  channel for remaining-count readback
- rd_count  out  WIDTH  combinational: remaining ticks of rd_ch
- free  out  CHANNELS  bit i high when channel i idle (count 0)
- expire  out  CHANNELS  bit i one-cycle pulse on channel i expiry
- paused  out  CHANNELS  bit i high while channel i paused

## Operation
- Per channel state: count[WIDTH], sub[$clog2(DIV)], period[WIDTH], periodic, paused.
- START, V>0: count=V, sub=DIV-1, periodic=0, paused=0. START_PERIODIC, V>0: same plus period=V, periodic=1.
- START/START_PERIODIC with V=0: behaves as CANCEL.
- CANCEL: count=0, sub=0, periodic=0, paused=0; no expire pulse.
- PAUSE_TOGGLE: inverts paused only when count>0; ignored on idle channel. While paused count/sub frozen, free stays 0.
- Running (count>0, not paused), per cycle: sub>0 -> sub-1; sub==0 and count>1 -> count-1, sub=DIV-1; sub==0 and count==1 -> expiry.
- Expiry one-shot: count=0, expire[i] pulses. Expiry periodic: count=period, sub=DIV-1, expire[i] pulses, free stays 0.
- Command on channel i in the cycle channel i would expire: command wins, expire[i] suppressed. Other channels unaffected.
- Commands to a channel never disturb other channels; all channels run in parallel.
- free[i] = (count==0); rd_count = count[rd_ch]; rd_ch >= CHANNELS returns 0.

## Timing
- Reset: all count, sub, period, periodic, paused = 0; free = all ones, expire = 0, paused = 0, rd_count = 0.
- Command sampled at edge E0; free[i] low from E0 onward; rd_count shows V after E0.
- One-shot V: count reaches 0 at edge E0 + V*DIV; free[i] high and expire[i] high for exactly the cycle after that edge.
- Periodic V: expire[i] pulses after edges E0 + k*V*DIV, k = 1,2,...; pulse spacing exactly V*DIV cycles.
- Pause for P cycles delays expiry by exactly P cycles (toggle edge to toggle edge).
- Restart of a running channel reloads from E0; previous expiry never issued.
- rst mid-operation: all channels idle immediately, no expire pulse on release.
- count arithmetic unsigned, WIDTH bits; max delay (2^WIDTH-1)*DIV cycles; no wrap since count never decrements below 1 except via expiry.

## Structure
- Package timer_pkg: op encodings (OP_START, OP_START_PERIODIC, OP_CANCEL, OP_PAUSE), DIV and sub-counter width derived from `FREQUENCY and TICK_HZ.
- Sub-module timer_channel: one channel (count/sub/period/flags, decoded cmd strobe in, free/expire/paused/count out); timer_bank decodes cmd_ch, generates CHANNELS instances, muxes rd_count.

## Test plan
Bench uses FREQUENCY=8000, TICK_HZ=1000 (DIV=8), CHANNELS=4, WIDTH=8.
- Reset then idle -> free=4'b1111, expire=0, paused=0, rd_count=0.
- START ch0 V=3 at E0 -> free[0]=0, expire[0] single pulse in cycle after E0+24, free[0]=1 thereafter; other channels untouched.
- START_PERIODIC ch1 V=2 -> expire[1] pulses every 16 cycles for 5 periods; CANCEL -> no further pulses, free[1]=1.
- START ch2 V=4, PAUSE_TOGGLE at E0+5, again at E0+15 -> expire[2] after E0+42, rd_count frozen at 4 while paused.
- START ch3 V=1; at expiry cycle issue START ch3 V=2 -> no expire at E0+8, expire after E0+8+16; simultaneous ch0 expiry still pulses.
- START ch0 V=0 and PAUSE_TOGGLE on idle ch1 -> no state change, no pulse; rst asserted mid-count -> all free, no expire.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel tick timer bank:
// command opcodes, tick divider and sub-counter width helpers.
`ifndef FREQUENCY
`define FREQUENCY 8000
`endif

package timer_pkg;

  typedef enum logic [1:0] {
    OP_START          = 2'd0,
    OP_START_PERIODIC = 2'd1,
    OP_CANCEL         = 2'd2,
    OP_PAUSE          = 2'd3
  } op_e;

  localparam int unsigned FREQ_HZ = `FREQUENCY;

  // Clock cycles per tick.
  function automatic int unsigned div_of(
    input int unsigned tick_hz
  );
    return FREQ_HZ / tick_hz;
  endfunction

  // Width of the cycles-within-tick counter.
  function automatic int unsigned sub_w(
    input int unsigned div
  );
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  // Channel select width, at least one bit.
  function automatic int unsigned ch_w(
    input int unsigned n
  );
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: tick down-counter with one-shot/periodic
// reload, cancel and pause.
// Ports: clk, rst, cmd_en/cmd_op/cmd_value in;
// free, expire (registered pulse), paused, count out.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV   = 8,
  parameter int unsigned SW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_en,
  input  op_e              cmd_op,
  input  logic [WIDTH-1:0] cmd_value,
  output logic             free,
  output logic             expire,
  output logic             paused,
  output logic [WIDTH-1:0] count
);

  localparam logic [SW-1:0] SUB_TOP = SW'(DIV - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [SW-1:0]    sub_q, sub_d;
  logic             periodic_q, periodic_d;
  logic             paused_q, paused_d;
  logic             expire_q, expire_d;
  logic             fire;

  always_comb begin
    count_d    = count_q;
    period_d   = period_q;
    sub_d      = sub_q;
    periodic_d = periodic_q;
    paused_d   = paused_q;
    fire       = 1'b0;

    if (count_q != '0 && !paused_q) begin
      if (sub_q != '0) begin
        sub_d = sub_q - SW'(1);
      end else if (count_q != WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
        sub_d   = SUB_TOP;
      end else begin
        fire = 1'b1;
        if (periodic_q) begin
          count_d = period_q;
          sub_d   = SUB_TOP;
        end else begin
          count_d = '0;
        end
      end
    end

    expire_d = fire;

    // A command overrides this cycle's tick, including expiry.
    if (cmd_en) begin
      unique case (cmd_op)
        OP_START, OP_START_PERIODIC: begin
          expire_d   = 1'b0;
          paused_d   = 1'b0;
          periodic_d = 1'b0;
          if (cmd_value != '0) begin
            count_d = cmd_value;
            sub_d   = SUB_TOP;
            if (cmd_op == OP_START_PERIODIC) begin
              period_d   = cmd_value;
              periodic_d = 1'b1;
            end
          end else begin
            count_d = '0;
            sub_d   = '0;
          end
        end
        OP_CANCEL: begin
          expire_d   = 1'b0;
          count_d    = '0;
          sub_d      = '0;
          periodic_d = 1'b0;
          paused_d   = 1'b0;
        end
        OP_PAUSE: begin
          if (count_q != '0) begin
            paused_d = !paused_q;
            if (fire) begin
              count_d  = count_q;
              sub_d    = sub_q;
              expire_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      period_q   <= '0;
      sub_q      <= '0;
      periodic_q <= 1'b0;
      paused_q   <= 1'b0;
      expire_q   <= 1'b0;
    end else begin
      count_q    <= count_d;
      period_q   <= period_d;
      sub_q      <= sub_d;
      periodic_q <= periodic_d;
      paused_q   <= paused_d;
      expire_q   <= expire_d;
    end
  end

  assign free   = (count_q == '0);
  assign expire = expire_q;
  assign paused = paused_q;
  assign count  = count_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of CHANNELS independent tick timers sharing one command port.
// Ports: clk, rst, cmd_valid/cmd_ch/cmd_op/cmd_value, rd_ch in;
// rd_count (combinational), free, expire, paused out.
module timer_bank
  import timer_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned TICK_HZ  = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  input  logic [ch_w(CHANNELS)-1:0]    cmd_ch,
  input  logic [1:0]                   cmd_op,
  input  logic [WIDTH-1:0]             cmd_value,
  input  logic [ch_w(CHANNELS)-1:0]    rd_ch,
  output logic [WIDTH-1:0]             rd_count,
  output logic [CHANNELS-1:0]          free,
  output logic [CHANNELS-1:0]          expire,
  output logic [CHANNELS-1:0]          paused
);

  localparam int unsigned CW  = ch_w(CHANNELS);
  localparam int unsigned DIV = div_of(TICK_HZ);
  localparam int unsigned SW  = sub_w(DIV);

  logic [WIDTH-1:0] cnt [CHANNELS];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    timer_channel #(
      .WIDTH (WIDTH),
      .DIV   (DIV),
      .SW    (SW)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .cmd_en    (cmd_valid && cmd_ch == CW'(gi)),
      .cmd_op    (op_e'(cmd_op)),
      .cmd_value (cmd_value),
      .free      (free[gi]),
      .expire    (expire[gi]),
      .paused    (paused[gi]),
      .count     (cnt[gi])
    );
  end

  // Out-of-range rd_ch falls through to zero.
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_ch == CW'(i)) rd_count = cnt[i];
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Directed test of timer_bank: 4 channels, 8-bit count, DIV=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_timer_bank;
  import timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_ch = '0;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_value = '0;
  logic [1:0] rd_ch = '0;
  logic [7:0] rd_count;
  logic [3:0] free, expire, paused;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  timer_bank #(
    .CHANNELS (4),
    .WIDTH    (8),
    .TICK_HZ  (1000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ch    (cmd_ch),
    .cmd_op    (cmd_op),
    .cmd_value (cmd_value),
    .rd_ch     (rd_ch),
    .rd_count  (rd_count),
    .free      (free),
    .expire    (expire),
    .paused    (paused)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; returns just after the sampling edge.
  task automatic issue(
    input logic [1:0] ch,
    input op_e        op,
    input logic [7:0] v
  );
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_op    = op;
    cmd_value = v;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_value = '0;
  endtask

  int pulses;

  initial begin
    step(2);
    rst = 1'b0;
    step(1);

    check("rst_free", 32'(free), 32'hf);
    check("rst_expire", 32'(expire), 32'h0);
    check("rst_paused", 32'(paused), 32'h0);
    check("rst_count", 32'(rd_count), 32'h0);

    // One-shot, ch0 V=3: expiry at E0+24.
    rd_ch = 2'd0;
    issue(2'd0, OP_START, 8'd3);
    check("os_busy", 32'(free), 32'he);
    check("os_cnt0", 32'(rd_count), 32'd3);
    step(8);
    check("os_cnt8", 32'(rd_count), 32'd2);
    step(15);
    check("os_pre", 32'(expire), 32'h0);
    check("os_pre_free", 32'(free[0]), 32'h0);
    step(1);
    check("os_exp", 32'(expire), 32'h1);
    check("os_free", 32'(free), 32'hf);
    step(1);
    check("os_post", 32'(expire), 32'h0);

    // Periodic, ch1 V=2: pulse every 16 cycles.
    issue(2'd1, OP_START_PERIODIC, 8'd2);
    for (int k = 1; k <= 5; k++) begin
      step(15);
      check($sformatf("per_gap%0d", k), 32'(expire[1]), 32'h0);
      step(1);
      check($sformatf("per_exp%0d", k), 32'(expire), 32'h2);
      check($sformatf("per_busy%0d", k), 32'(free[1]), 32'h0);
    end
    issue(2'd1, OP_CANCEL, 8'd0);
    check("can_free", 32'(free), 32'hf);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (expire != 4'h0) pulses++;
      step(1);
    end
    check("can_quiet", 32'(pulses), 32'd0);

    // Pause ch2 V=4 from E0+5 to E0+15: expiry at E0+42.
    rd_ch = 2'd2;
    issue(2'd2, OP_START, 8'd4);
    step(4);
    issue(2'd2, OP_PAUSE, 8'd0);
    check("pz_on", 32'(paused), 32'h4);
    check("pz_cnt_a", 32'(rd_count), 32'd4);
    step(9);
    check("pz_cnt_b", 32'(rd_count), 32'd4);
    check("pz_busy", 32'(free[2]), 32'h0);
    issue(2'd2, OP_PAUSE, 8'd0);
    check("pz_off", 32'(paused), 32'h0);
    step(26);
    check("pz_pre", 32'(expire), 32'h0);
    step(1);
    check("pz_exp", 32'(expire), 32'h4);

    // Restart ch3 at its expiry cycle; ch0 expires in the same cycle.
    step(1);
    rd_ch = 2'd3;
    issue(2'd0, OP_START, 8'd2);
    step(7);
    issue(2'd3, OP_START, 8'd1);
    step(7);
    issue(2'd3, OP_START, 8'd2);
    check("rs_exp", 32'(expire), 32'h1);
    check("rs_busy", 32'(free[3]), 32'h0);
    check("rs_cnt", 32'(rd_count), 32'd2);
    step(15);
    check("rs_pre", 32'(expire), 32'h0);
    step(1);
    check("rs_exp2", 32'(expire), 32'h8);

    // V=0 start and pause on an idle channel do nothing.
    step(1);
    rd_ch = 2'd0;
    issue(2'd0, OP_START, 8'd0);
    check("z_free", 32'(free), 32'hf);
    check("z_cnt", 32'(rd_count), 32'd0);
    issue(2'd1, OP_PAUSE, 8'd0);
    check("z_paused", 32'(paused), 32'h0);
    check("z_expire", 32'(expire), 32'h0);

    // Asynchronous reset mid-count.
    rd_ch = 2'd2;
    issue(2'd2, OP_START, 8'd5);
    step(10);
    check("rm_busy", 32'(free), 32'hb);
    rst = 1'b1;
    #1;
    check("rm_free", 32'(free), 32'hf);
    check("rm_cnt", 32'(rd_count), 32'd0);
    step(2);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      if (expire != 4'h0) pulses++;
      step(1);
    end
    check("rm_quiet", 32'(pulses), 32'd0);
    check("rm_free2", 32'(free), 32'hf);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
